sar_search_controller: RTL and testbench
========================================

Name: sar_search_controller

Overview:
- Initiator side of the magnitude-compare interface: drives a trial value and consumes greater/equal/less responses.
- Recovers an unknown WIDTH-bit target by successive approximation, MSB first, with early exit on equality.
- The target sits on the comparator's b side; guess drives the a side.
- Responder may be purely combinational (r_valid tied to q_valid) or registered with arbitrary latency, bounded by TIMEOUT.

Parameters:
WIDTH, 8, width of guess/target/result
TIMEOUT, 15, max cycles ASK may wait for r_valid before aborting with err

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a search; sampled only in IDLE
q_valid  out  1  query outstanding; guess is stable while high
guess  out  WIDTH  trial value, to comparator a input
r_valid  in  1  responder has a valid answer for the current guess
agb  in  1  guess > target
aeb  in  1  guess == target
alb  in  1  guess < target
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in DONE
result  out  WIDTH  recovered target, held until next start
steps  out  clog2(WIDTH+1)  responses consumed by last search, held
found  out  1  search ended on aeb (early/exact hit), held
err  out  1  last search aborted (non-one-hot response or timeout), held

Behaviour:
- Reset (async, any state): state=IDLE; guess, result, steps=0; q_valid, done, found, err=0; bit index=WIDTH-1; wait counter=0.
- States: IDLE, ASK, DONE.
- IDLE: when start=1, go to ASK with guess=1<<(WIDTH-1), bit=WIDTH-1, steps=0, wait=0, and found/err cleared. start is ignored in ASK and DONE (no queuing).
- ASK: q_valid=1; guess must not change until the response is accepted.
- Response accept: the cycle where ASK and r_valid=1. On accept, steps increments.
- Response not exactly one-hot: err=1, result=guess, go to DONE.
- aeb: found=1, result=guess, go to DONE.
- agb: clear guess[bit]. alb: keep guess[bit].
- If bit==0 after an agb/alb response: result=updated guess, found=0, go to DONE.
- Otherwise, for agb/alb: bit decrements, guess[bit-1] is set, remain in ASK. q_valid stays high, so a combinational responder gives back-to-back queries, one per cycle.
- Wait counter: increments each ASK cycle without r_valid and clears on accept. If it reaches TIMEOUT: err=1, result=guess, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. q_valid=0.
- Invariant: on non-error completion, result equals the target.
- Step count: steps = WIDTH-k on an aeb exit, where k is the target's lowest set bit. A target of 0 gives WIDTH steps with found=0.
- Latency with a combinational responder: start sampled at T0; first query at T1; done at T(1+steps).
- Simultaneous events: start and a reset edge together means reset wins. r_valid outside ASK is ignored.

Decomposition:
- Shared package sar_pkg holds:
  - state enum {IDLE, ASK, DONE};
  - default WIDTH and TIMEOUT constants;
  - a function for the steps width (clog2(WIDTH+1)).
- No RTL sub-module is needed; one-hot checking is a single expression.
- The bench responder is the team's existing eight-bit comparator, with target on b and r_valid=q_valid. A registered wrapper around it covers multi-cycle latency.

Test Plan:
1. Target 0x80, combinational responder, start at T0 -> guess 0x80 at T1, done at T2, result 0x80, steps 1, found 1, err 0.
2. Target 0x00 -> guesses 0x80,0x40,…,0x01; done at T9; result 0x00, steps 8, found 0.
3. Target 0x5A -> guesses 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A; aeb exit; result 0x5A, steps 7, found 1.
4. Target 0xFF with responder latency 3 cycles -> guess holds stable while q_valid waits; result 0xFF, steps 8, found 1; done 4 cycles per step after start.
5. Responder never asserts r_valid -> after 15 ASK cycles, err=1, done pulses, result 0x80, steps 0. Separately, a response with agb=aeb=1 -> err=1 at that step.
6. Target 0x33: deassert rst_n at 3rd query -> all outputs immediately 0, state IDLE. A new start completes with result 0x33, steps 8, found 1. Start pulsed mid-search is ignored; the next start after done is accepted.

Source files
------------

// File: rtl/sar_pkg.sv
// ----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the successive-approximation search controller:
//   - state_t          : controller states (IDLE, ASK, DONE)
//   - DEFAULT_WIDTH    : default width of guess/target/result
//   - DEFAULT_TIMEOUT  : default number of ASK cycles allowed without r_valid
//   - steps_width()    : bits needed to hold a step count of 0..WIDTH
// ----------------------------------------------------------------------------
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASK  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 15;

    // A search consumes at most WIDTH responses, so the counter must reach WIDTH.
    function automatic int steps_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sar_search_controller.sv
// ----------------------------------------------------------------------------
// sar_search_controller
// Initiator side of a magnitude-compare interface. Recovers an unknown
// WIDTH-bit target (on the comparator's b side) by driving trial values on
// guess (a side), MSB first, exiting early when the responder reports equal.
//
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start           : begin a search (only looked at while idle)
//   q_valid, guess  : query outstanding / trial value (stable while q_valid)
//   r_valid         : responder answer valid for the current guess
//   agb, aeb, alb   : guess >, ==, < target
//   busy            : controller not idle
//   done            : one-cycle completion pulse
//   result, steps   : recovered value / responses consumed (held)
//   found, err      : exact hit / aborted search (held)
// ----------------------------------------------------------------------------
module sar_search_controller
    import sar_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           q_valid,
    output logic [WIDTH-1:0]               guess,
    input  logic                           r_valid,
    input  logic                           agb,
    input  logic                           aeb,
    input  logic                           alb,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH-1:0]               result,
    output logic [steps_width(WIDTH)-1:0]  steps,
    output logic                           found,
    output logic                           err
);

    localparam int SW = steps_width(WIDTH);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  guess_q, guess_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [SW-1:0]     steps_q, steps_d;
    logic              found_q, found_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  trial;
    logic              one_hot;

    assign one_hot = $onehot({agb, aeb, alb});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            bit_q    <= BW'(WIDTH - 1);
            wait_q   <= '0;
            result_q <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        result_d = result_q;
        steps_d  = steps_q;
        found_d  = found_q;
        err_d    = err_q;
        trial    = guess_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d            = ASK;
                    guess_d            = '0;
                    guess_d[WIDTH-1]   = 1'b1;
                    bit_d              = BW'(WIDTH - 1);
                    wait_d             = '0;
                    steps_d            = '0;
                    found_d            = 1'b0;
                    err_d              = 1'b0;
                end
            end

            ASK: begin
                if (r_valid) begin
                    steps_d = steps_q + 1'b1;
                    wait_d  = '0;
                    if (!one_hot) begin
                        err_d    = 1'b1;
                        result_d = guess_q;
                        state_d  = DONE;
                    end else if (aeb) begin
                        found_d  = 1'b1;
                        result_d = guess_q;
                        state_d  = DONE;
                    end else begin
                        // Too high: drop the trial bit; too low: keep it.
                        if (agb) begin
                            trial[bit_q] = 1'b0;
                        end
                        if (bit_q == '0) begin
                            result_d = trial;
                            found_d  = 1'b0;
                            guess_d  = trial;
                            state_d  = DONE;
                        end else begin
                            trial[bit_q - 1'b1] = 1'b1;
                            bit_d               = bit_q - 1'b1;
                            guess_d             = trial;
                        end
                    end
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive cycle without an answer.
                    err_d    = 1'b1;
                    result_d = guess_q;
                    state_d  = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q_valid = (state_q == ASK);
    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign guess   = guess_q;
    assign result  = result_q;
    assign steps   = steps_q;
    assign found   = found_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// ----------------------------------------------------------------------------
// tb_sar_search_controller
// Drives searches against an eight-bit comparator responder (target on b,
// optional fixed latency, silent mode, or a forced two-hot answer) and checks
// every accepted guess and each search's final outputs against a reference
// successive-approximation model held in scoreboard queues.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sar_search_controller;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [7:0] res;
        int         steps;
        logic       found;
        logic       err;
        int         cycles;
    } expect_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       q_valid;
    logic [7:0] guess;
    logic       r_valid;
    logic       agb;
    logic       aeb;
    logic       alb;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] steps;
    logic       found;
    logic       err;

    logic [7:0] target;
    int         latency;
    logic       silent;
    int         bad_at;
    int         lat_cnt;
    int         resp_cnt;
    logic       bad_now;

    logic [7:0] expGuess[$];
    expect_t    expResult[$];

    int nCompared;
    int nMismatched;

    logic       prevWait;
    logic [7:0] prevGuess;

    sar_search_controller #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .q_valid (q_valid),
        .guess   (guess),
        .r_valid (r_valid),
        .agb     (agb),
        .aeb     (aeb),
        .alb     (alb),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .steps   (steps),
        .found   (found),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator responder; r_valid appears once q_valid has been up for 'latency' cycles.
    assign bad_now = (bad_at != 0) && (resp_cnt == bad_at - 1);
    assign r_valid = q_valid && !silent && (lat_cnt == latency);
    assign agb     = (guess > target)  || bad_now;
    assign aeb     = (guess == target) || bad_now;
    assign alb     = (guess < target)  && !bad_now;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt  <= 0;
            resp_cnt <= 0;
        end else begin
            if (q_valid && r_valid) begin
                lat_cnt  <= 0;
                resp_cnt <= resp_cnt + 1;
            end else if (q_valid) begin
                lat_cnt  <= lat_cnt + 1;
            end else begin
                lat_cnt  <= 0;
            end
            if (!busy) begin
                resp_cnt <= 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Each accepted query must carry the next guess of the reference model,
    // and a waiting query must hold its guess.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevWait = 1'b0;
        end else begin
            if (q_valid && prevWait) begin
                checkOutput("guess_stable", guess, prevGuess);
            end
            if (q_valid && r_valid) begin
                if (expGuess.size() > 0) begin
                    checkOutput("guess", guess, expGuess.pop_front());
                end else begin
                    checkOutput("extra_query", 32'(expGuess.size()), 32'd1);
                end
            end
            prevWait  = q_valid && !r_valid;
            prevGuess = guess;
        end
    end

    task automatic buildModel(input logic [7:0] tgt, input int lat, input logic sil,
                              input int badStep);
        expect_t    e;
        logic [7:0] g;
        logic [7:0] tr;
        g        = 8'h00;
        e.res    = 8'h00;
        e.steps  = 0;
        e.found  = 1'b0;
        e.err    = 1'b0;
        if (sil) begin
            e.res    = 8'h80;
            e.err    = 1'b1;
            e.cycles = 1 + TIMEOUT;
        end else begin
            for (int b = 7; b >= 0; b--) begin
                tr = g | (8'h01 << b);
                expGuess.push_back(tr);
                e.steps++;
                if (badStep == e.steps) begin
                    e.err = 1'b1;
                    e.res = tr;
                    break;
                end
                if (tr == tgt) begin
                    e.found = 1'b1;
                    e.res   = tr;
                    break;
                end
                if (tr < tgt) g = tr;
                if (b == 0) e.res = g;
            end
            e.cycles = 1 + e.steps * (lat + 1);
        end
        expResult.push_back(e);
    endtask

    // Runs one search; midStart > 0 pulses start during that cycle of the search.
    task automatic applyStimulus(input logic [7:0] tgt, input int lat, input logic sil,
                                 input int badStep, input int midStart);
        expect_t e;
        int      cnt;
        target  = tgt;
        latency = lat;
        silent  = sil;
        bad_at  = badStep;
        buildModel(tgt, lat, sil, badStep);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (midStart > 0 && cnt == midStart) start = 1'b1;
            if (midStart > 0 && cnt == midStart + 1) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        e = expResult.pop_front();
        checkOutput("done_cycle", cnt, e.cycles);
        checkOutput("result", result, e.res);
        checkOutput("steps", steps, e.steps);
        checkOutput("found", found, e.found);
        checkOutput("err", err, e.err);
        checkOutput("busy_in_done", busy, 1'b1);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("busy_after", busy, 1'b0);
        checkOutput("guess_q_drained", 32'(expGuess.size()), 32'd0);
        expGuess.delete();
        bad_at = 0;
        silent = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_q_valid"}, q_valid, 1'b0);
        checkOutput({tag, "_guess"},   guess,   8'h00);
        checkOutput({tag, "_busy"},    busy,    1'b0);
        checkOutput({tag, "_done"},    done,    1'b0);
        checkOutput({tag, "_result"},  result,  8'h00);
        checkOutput({tag, "_steps"},   steps,   4'd0);
        checkOutput({tag, "_found"},   found,   1'b0);
        checkOutput({tag, "_err"},     err,     1'b0);
    endtask

    // Resets mid-search at the third query, and shows start is ignored during reset.
    task automatic resetMidSearch();
        expect_t dummy;
        int      cnt;
        target  = 8'h33;
        latency = 0;
        silent  = 1'b0;
        bad_at  = 0;
        buildModel(8'h33, 0, 1'b0, 0);
        dummy = expResult.pop_back();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            #2;
            cnt++;
            if (resp_cnt == 2) break;
        end
        checkOutput("third_query_reached", resp_cnt, 2);
        checkOutput("third_query_valid", q_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        expGuess.delete();
        checkIdleOutputs("midreset");
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("start_during_reset_busy", busy, 1'b0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", busy, 1'b0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        prevWait    = 1'b0;
        prevGuess   = 8'h00;
        rst_n       = 1'b0;
        start       = 1'b0;
        target      = 8'h00;
        latency     = 0;
        silent      = 1'b0;
        bad_at      = 0;

        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h80, 0, 1'b0, 0, 0);
        applyStimulus(8'h00, 0, 1'b0, 0, 0);
        applyStimulus(8'h5A, 0, 1'b0, 0, 0);
        applyStimulus(8'hFF, 3, 1'b0, 0, 0);
        applyStimulus(8'h80, 0, 1'b1, 0, 0);
        applyStimulus(8'h5A, 0, 1'b0, 3, 0);
        applyStimulus(8'h5A, 0, 1'b0, 1, 0);

        resetMidSearch();
        applyStimulus(8'h33, 0, 1'b0, 0, 3);
        applyStimulus(8'hC4, 0, 1'b0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
